// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage, directly downstream of the execute stage.
// Registers the EX->MEM bus, consumes the synchronous data-SRAM read data
// that returns one cycle after EX issued a load, aligns and sign/zero-extends
// it, and produces the MEM->WB bus plus an identical forwarding copy for ID.
// A small hold buffer keeps the returned load data alive while MEM is stalled,
// because the SRAM read port only presents it for a single cycle.
//
// Ports:
//   clk              clock, rising edge active
//   resetn           asynchronous active-low reset
//   stall            per-stage stall bus; bit3 = EX, bit4 = MEM; 1 = stop
//   ex_to_mem_bus    {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr,
//                     ex_result, hi_we, lo_we, hi_wdata, lo_wdata,
//                     ram_wen_dup}, MSB first
//   data_sram_rdata  SRAM read data for the load now sitting in MEM
//   mem_to_wb_bus    {pc, rf_we, rf_waddr, rf_wdata, hi_we, lo_we,
//                     hi_wdata, lo_wdata}
//   mem_to_id_bus    identical copy of mem_to_wb_bus, used for forwarding
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_id_bus
);

    // -------------------------------------------------------------------------
    // Bus layouts
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
        logic [3:0]  ram_wen_dup;
    } ex_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_wdata;
        logic [31:0] lo_wdata;
    } wb_bus_t;

    // Load encodings carried on ram_wen when ram_en is set. Stores use the
    // remaining codes (1111 / 1101 / 1110) and never touch the read path.
    localparam logic [3:0] LD_W  = 4'b0000;
    localparam logic [3:0] LD_B  = 4'b0001;
    localparam logic [3:0] LD_BU = 4'b0010;
    localparam logic [3:0] LD_H  = 4'b0100;
    localparam logic [3:0] LD_HU = 4'b0110;

    // -------------------------------------------------------------------------
    // Stall decode
    // -------------------------------------------------------------------------
    logic stall_ex;
    logic stall_mem;

    assign stall_ex  = stall[3];
    assign stall_mem = stall[4];

    // -------------------------------------------------------------------------
    // EX->MEM pipeline register
    // -------------------------------------------------------------------------
    logic [EX_TO_MEM_WD-1:0] bus_r;
    ex_bus_t                 mem_bus;

    // EX stopped while MEM keeps going: MEM must not re-execute the same
    // instruction, so a bubble (all zero, rf_we = 0) is inserted instead.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values present before the edge regardless of the
    // order the always_ff blocks are evaluated in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (stall_ex && !stall_mem) begin
            bus_r <= '0;
        end else if (!stall_ex) begin
            bus_r <= ex_to_mem_bus;
        end
    end

    assign mem_bus = ex_bus_t'(bus_r);

    // -------------------------------------------------------------------------
    // Load classification
    // -------------------------------------------------------------------------
    logic is_load;

    // NOTE: every signal assigned in an always_comb gets a default on entry, so
    // no path through the case statements can leave it unassigned and infer a
    // latch.
    always_comb begin
        is_load = 1'b0;
        if (mem_bus.ram_en) begin
            case (mem_bus.ram_wen)
                LD_W, LD_B, LD_BU, LD_H, LD_HU: is_load = 1'b1;
                default:                        is_load = 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read-data hold buffer
    // -------------------------------------------------------------------------
    // The SRAM returns load data exactly one cycle after the request. If MEM
    // is stalled in that cycle the data would be lost on the next cycle, so it
    // is captured on the first stalled edge and replayed until MEM advances.
    // The capture is gated by hold_valid so a multi-cycle stall keeps the
    // original data rather than whatever the SRAM port shows later.
    logic        hold_valid;
    logic [31:0] hold_data;
    logic [31:0] rdata_eff;

    // NOTE: hold_data is a single 32-bit register rather than a storage array,
    // so it shares the asynchronous reset with hold_valid; it is only ever
    // consumed when hold_valid is set, but a defined reset value keeps the
    // output bus free of X after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (!stall_mem) begin
            // MEM advances or bubbles: the held data belongs to an instruction
            // that is leaving the stage. Clear wins over capture.
            hold_valid <= 1'b0;
        end else if (is_load && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= data_sram_rdata;
        end
    end

    assign rdata_eff = hold_valid ? hold_data : data_sram_rdata;

    // -------------------------------------------------------------------------
    // Load alignment and extension
    // -------------------------------------------------------------------------
    logic [1:0]  addr_lo;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;

    assign addr_lo = mem_bus.ex_result[1:0];

    always_comb begin
        byte_sel = rdata_eff[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata_eff[7:0];
            2'd1:    byte_sel = rdata_eff[15:8];
            2'd2:    byte_sel = rdata_eff[23:16];
            default: byte_sel = rdata_eff[31:24];
        endcase
    end

    // A misaligned halfword (addr_lo[0] = 1) is architecturally undefined; it
    // simply follows addr_lo[1], which keeps the result deterministic.
    assign half_sel = addr_lo[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    always_comb begin
        load_result = rdata_eff;
        case (mem_bus.ram_wen)
            LD_B:    load_result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_result = {24'd0, byte_sel};
            LD_H:    load_result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_result = {16'd0, half_sel};
            default: load_result = rdata_eff;
        endcase
    end

    // -------------------------------------------------------------------------
    // MEM->WB / MEM->ID buses
    // -------------------------------------------------------------------------
    wb_bus_t wb_bus;

    always_comb begin
        wb_bus          = '0;
        wb_bus.pc       = mem_bus.pc;
        wb_bus.rf_we    = mem_bus.rf_we;
        wb_bus.rf_waddr = mem_bus.rf_waddr;
        wb_bus.rf_wdata = mem_bus.sel_rf_res ? load_result : mem_bus.ex_result;
        wb_bus.hi_we    = mem_bus.hi_we;
        wb_bus.lo_we    = mem_bus.lo_we;
        wb_bus.hi_wdata = mem_bus.hi_wdata;
        wb_bus.lo_wdata = mem_bus.lo_wdata;
    end

    assign mem_to_wb_bus = wb_bus;
    assign mem_to_id_bus = wb_bus;

    // The duplicated write-enable field and the stall bits of other stages are
    // part of the shared bus formats but carry nothing this stage needs.
    logic unused_bits;
    assign unused_bits = ^{mem_bus.ram_wen_dup, stall};

endmodule
